// File: rtl/scene_pkg.sv
// Shared types and constants for the scene loader: FSM states, framing bytes and record layout.
package scene_pkg;

  typedef enum logic [1:0] {HUNT, LOAD, CSUM} state_t;

  typedef enum logic [2:0] {F_LOC_X, F_LOC_Y, F_VELO_X, F_VELO_Y, F_MASS, F_RADIUS} field_t;

  localparam logic [7:0]  SYNC_BYTE        = 8'hA5;
  localparam int unsigned BYTES_PER_SPRITE = 19;

  localparam int unsigned OFF_LOC_X  = 0;
  localparam int unsigned OFF_LOC_Y  = 4;
  localparam int unsigned OFF_VELO_X = 8;
  localparam int unsigned OFF_VELO_Y = 12;
  localparam int unsigned OFF_MASS   = 16;
  localparam int unsigned OFF_RADIUS = 18;

  // Maps a byte position within a record onto the field it belongs to.
  function automatic field_t field_of(input int unsigned idx);
    case (idx) inside
      [OFF_LOC_X:OFF_LOC_Y-1]:   return F_LOC_X;
      [OFF_LOC_Y:OFF_VELO_X-1]:  return F_LOC_Y;
      [OFF_VELO_X:OFF_VELO_Y-1]: return F_VELO_X;
      [OFF_VELO_Y:OFF_MASS-1]:   return F_VELO_Y;
      [OFF_MASS:OFF_RADIUS-1]:   return F_MASS;
      default:                   return F_RADIUS;
    endcase
  endfunction

endpackage

// File: rtl/scene_loader_if.sv
// Byte-stream valid/ready channel feeding the scene loader.
interface scene_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/scene_timeout.sv
// Idle-cycle watchdog: expired pulses on the TIMEOUT-th consecutive enabled cycle without clear.
module scene_timeout #(
  parameter int unsigned TIMEOUT = 1_620_000
) (
  input  logic clk_162,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_162 or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/scene_loader.sv
// Receives framed scene records into shadow registers and commits them to the outputs
// only when the trailing XOR checksum matches.
module scene_loader
  import scene_pkg::*;
#(
  parameter int unsigned SPRITES    = 9,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIMENSIONS = 2,
  parameter int unsigned TIMEOUT    = 1_620_000
) (
  input  logic                                           clk_162,
  input  logic                                           rst,
  scene_loader_if.slave                                  rx,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  init_locations,
  output logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0]  init_velos,
  output logic [SPRITES-1:0][WIDTH/2-1:0]                masses,
  output logic [SPRITES-1:0][6:0]                        radii,
  output logic                                           data_ready,
  output logic                                           frame_error
);

  localparam int unsigned SW = (SPRITES > 1) ? $clog2(SPRITES) : 1;

  state_t          state, state_next;
  logic [4:0]      byte_cnt;
  logic [SW-1:0]   sprite;
  logic [7:0]      csum;
  logic            ready_q;
  logic            xfer, last_byte, expired, commit, reject;

  logic [SPRITES-1:0][DIMENSIONS-1:0][WIDTH-1:0] shadow_loc, shadow_velo;
  logic [SPRITES-1:0][WIDTH/2-1:0]               shadow_mass;
  logic [SPRITES-1:0][6:0]                       shadow_rad;

  assign rx.rx_ready = ready_q;
  assign xfer        = rx.rx_valid && ready_q;
  assign last_byte   = (sprite == SW'(SPRITES - 1)) && (byte_cnt == 5'(BYTES_PER_SPRITE - 1));

  scene_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_162 (clk_162),
    .rst     (rst),
    .clear   (xfer || state == HUNT),
    .enable  (state != HUNT),
    .expired (expired)
  );

  always_ff @(posedge clk_162 or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    reject     = 1'b0;
    case (state)
      HUNT: if (xfer && rx.rx_data == SYNC_BYTE) state_next = LOAD;
      LOAD: begin
        if (expired)                state_next = HUNT;
        else if (xfer && last_byte) state_next = CSUM;
      end
      CSUM: begin
        if (expired) begin
          state_next = HUNT;
        end else if (xfer) begin
          state_next = HUNT;
          commit     = (rx.rx_data == csum);
          reject     = (rx.rx_data != csum);
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk_162 or posedge rst) begin
    if (rst) begin
      ready_q        <= 1'b0;
      data_ready     <= 1'b0;
      frame_error    <= 1'b0;
      byte_cnt       <= '0;
      sprite         <= '0;
      csum           <= '0;
      init_locations <= '0;
      init_velos     <= '0;
      masses         <= '0;
      radii          <= '0;
    end else begin
      ready_q     <= 1'b1;
      data_ready  <= commit;
      frame_error <= reject | expired;
      if (commit) begin
        init_locations <= shadow_loc;
        init_velos     <= shadow_velo;
        masses         <= shadow_mass;
        radii          <= shadow_rad;
      end
      // Every way back to HUNT (commit, bad checksum, timeout) leaves the framing state clean.
      if (state_next == HUNT) begin
        byte_cnt <= '0;
        sprite   <= '0;
        csum     <= '0;
      end else if (state == LOAD && xfer) begin
        csum <= csum ^ rx.rx_data;
        if (byte_cnt == 5'(BYTES_PER_SPRITE - 1)) begin
          byte_cnt <= '0;
          sprite   <= (sprite == SW'(SPRITES - 1)) ? '0 : sprite + SW'(1);
        end else begin
          byte_cnt <= byte_cnt + 5'd1;
        end
      end
    end
  end

  // Big-endian fields: shifting each byte in from the right leaves the MSB first.
  always_ff @(posedge clk_162 or posedge rst) begin
    if (rst) begin
      shadow_loc  <= '0;
      shadow_velo <= '0;
      shadow_mass <= '0;
      shadow_rad  <= '0;
    end else if (state == LOAD && xfer) begin
      case (field_of(32'(byte_cnt)))
        F_LOC_X:  shadow_loc[sprite][0]  <= {shadow_loc[sprite][0][WIDTH-9:0], rx.rx_data};
        F_LOC_Y:  shadow_loc[sprite][1]  <= {shadow_loc[sprite][1][WIDTH-9:0], rx.rx_data};
        F_VELO_X: shadow_velo[sprite][0] <= {shadow_velo[sprite][0][WIDTH-9:0], rx.rx_data};
        F_VELO_Y: shadow_velo[sprite][1] <= {shadow_velo[sprite][1][WIDTH-9:0], rx.rx_data};
        F_MASS:   shadow_mass[sprite]    <= {shadow_mass[sprite][WIDTH/2-9:0], rx.rx_data};
        default:  shadow_rad[sprite]     <= rx.rx_data[6:0];
      endcase
    end
  end

endmodule

// File: doc/scene_loader.md
SCENE_LOADER -- requirements
Module: scene_loader

Interface
REQ-001 SHALL have parameter SPRITES, default 9, number of sprites per scene.
REQ-002 SHALL have parameter WIDTH, default 32, width of a location/velocity component.
REQ-003 SHALL have parameter DIMENSIONS, default 2, components per vector (0 = x, 1 = y).
REQ-004 SHALL have parameter TIMEOUT, default 1_620_000, maximum idle cycles allowed between bytes inside a frame.
REQ-005 SHALL have port clk_162, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port rx_data, input, 8, incoming scene byte.
REQ-008 SHALL have port rx_valid, input, 1, rx_data is valid.
REQ-009 SHALL have port rx_ready, output, 1, block accepts a byte; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-010 SHALL have port init_locations, output, [SPRITES][DIMENSIONS][WIDTH], committed initial positions.
REQ-011 SHALL have port init_velos, output, [SPRITES][DIMENSIONS][WIDTH], committed initial velocities.
REQ-012 SHALL have port masses, output, [SPRITES][WIDTH/2], committed masses.
REQ-013 SHALL have port radii, output, [SPRITES][7], committed radii.
REQ-014 SHALL have port data_ready, output, 1, one-cycle pulse marking a newly committed scene (feeds physics_engine.data_ready).
REQ-015 SHALL have port frame_error, output, 1, one-cycle pulse on a checksum mismatch or timeout.

Function
REQ-016 Frame format SHALL be: sync byte 0xA5, then SPRITES records, then one checksum byte.
REQ-017 Each record SHALL be 19 bytes in this order: loc x (4), loc y (4), velo x (4), velo y (4), mass (2), radius (1). Multi-byte fields SHALL be big-endian; the radius byte uses bits [6:0] and bit 7 is ignored.
REQ-018 Checksum SHALL be the XOR of all record bytes (the sync byte excluded).
REQ-019 FSM states SHALL be HUNT, LOAD, CSUM, with these transitions:
- HUNT -> LOAD on an accepted 0xA5; other bytes in HUNT are dropped.
- LOAD -> CSUM after byte 19*SPRITES is accepted.
- CSUM -> HUNT on the accepted checksum byte.
REQ-020 rx_ready SHALL be 1 in every state after reset is released; the block never back-pressures.
REQ-021 Record bytes SHALL be written into shadow registers only, never directly into the outputs; a byte counter and a sprite index (wrapping at SPRITES-1) select the field.
REQ-022 On a matching checksum, the outputs SHALL load from the shadow registers and data_ready SHALL go to 1 on the same edge, so the outputs are stable while data_ready is high. Latency from checksum acceptance to data_ready is 1 cycle.
REQ-023 On a mismatching checksum, the outputs SHALL be unchanged, frame_error SHALL pulse for 1 cycle, and the FSM returns to HUNT.
REQ-024 In LOAD or CSUM, if TIMEOUT consecutive cycles pass without a transfer, the FSM SHALL go to HUNT, frame_error SHALL pulse, the outputs SHALL be unchanged, and the counters and running XOR SHALL clear.
REQ-025 A 0xA5 byte received inside LOAD SHALL be treated as data, not as a resync.
REQ-026 data_ready and frame_error SHALL never be asserted in the same cycle.
REQ-027 Committed outputs SHALL hold indefinitely between frames; back-to-back frames are legal with zero gap.

Reset
REQ-028 Asserting rst SHALL immediately (asynchronously) force:
- state = HUNT, counters and running XOR = 0;
- all output arrays = 0;
- data_ready = 0, frame_error = 0, rx_ready = 0.
REQ-029 rx_ready SHALL go to 1 on the first clock edge after rst is released.
REQ-030 Reset during a frame SHALL discard the partial frame; no data_ready pulse results from it.

Structure
REQ-031 Package scene_pkg SHALL hold the FSM state enum, SYNC_BYTE = 8'hA5, BYTES_PER_SPRITE = 19, and the record field byte offsets.
REQ-032 The idle timeout counter SHALL be one sub-module, scene_timeout, with inputs clear and enable and a single-cycle expired output.

Verification
REQ-033 Send a valid frame with sprite 0 = loc (0x00010000, 0x00020000), velo (0, 0xFFFF0000), mass 0x0C00, radius 10; all other sprites zero -> data_ready pulses once, 1 cycle after the checksum byte, with exactly those values on the outputs.
REQ-034 Send the same frame with the checksum XORed by 0x01 -> frame_error pulses once, data_ready stays 0, and the outputs keep their previous values.
REQ-035 Send 0x00, 0x37 and then a valid frame -> the leading bytes are dropped and the frame commits normally.
REQ-036 Stall 1_620_000 cycles after byte 50 of a frame -> frame_error pulses and the next valid frame commits correctly.
REQ-037 Assert rst at byte 100 of a frame, then send a full valid frame -> the outputs are 0 during reset and only the second frame commits.
REQ-038 Send two valid frames back-to-back with rx_valid held at 1 -> exactly two data_ready pulses, and the outputs hold the second frame's values.
